// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller over an external dual-port memory with a 2-entry output buffer
//
// Purpose: turns a registered-read dual-port memory (memory_dp, both clocks tied
// to clk) into a ready/valid FIFO. Words are written into the memory and read
// back ahead of demand into a small output buffer, so the downstream side sees
// one word per cycle despite the one-cycle memory read latency.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_data  upstream ready/valid word interface
//   out_valid/out_ready/out_data downstream ready/valid word interface (oldest word)
//   mem_wr_en/addr/data        memory write port
//   mem_rd_en/addr, mem_rd_data memory read port; data valid the cycle after rd_en
//   level                      words held: memory + in-flight read + output buffer
`timescale 1ns/1ps

module mem_fifo_ctrl #(
  parameter int num_mem_entries = 8,
  parameter int data_bit_width  = 32,
  parameter int addr_bit_width  = $clog2(num_mem_entries)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [data_bit_width-1:0]               in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [data_bit_width-1:0]               out_data,
  output logic                                    mem_wr_en,
  output logic [addr_bit_width-1:0]               mem_wr_addr,
  output logic [data_bit_width-1:0]               mem_wr_data,
  output logic                                    mem_rd_en,
  output logic [addr_bit_width-1:0]               mem_rd_addr,
  input  logic [data_bit_width-1:0]               mem_rd_data,
  output logic [$clog2(num_mem_entries+3)-1:0]    level
);

  localparam int ptr_w   = addr_bit_width + 1;
  localparam int level_w = $clog2(num_mem_entries + 3);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ptr_w-1:0]          wr_ptr;
  logic [ptr_w-1:0]          rd_ptr;
  logic [ptr_w-1:0]          mem_count;
  logic                      rd_pending;
  logic [1:0]                ob_count;
  logic                      ob_head;
  logic [data_bit_width-1:0] ob_mem [2];

  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      issue;
  logic [1:0]                ob_next;
  logic                      ob_tail;

  assign mem_count = wr_ptr - rd_ptr;
  assign full      = (mem_count == ptr_w'(num_mem_entries));

  assign in_ready  = rst_n & ~full;
  assign push      = in_valid & in_ready;

  assign out_valid = (ob_count != 2'd0);
  assign out_data  = ob_mem[ob_head];
  assign pop       = out_valid & out_ready;

  // Occupancy the buffer will have after this edge, before counting a new issue.
  // ob_count + rd_pending never exceeds 2, so this cannot underflow or overflow.
  assign ob_next   = ob_count + {1'b0, rd_pending} - {1'b0, pop};

  // Prefetch only when the buffer plus the read about to land leaves a free slot.
  // Uses registered mem_count, so a word written this cycle is never read back now.
  assign issue     = rst_n & (mem_count != '0) & (ob_next < 2'd2);

  assign mem_wr_en   = push;
  assign mem_wr_addr = wr_ptr[addr_bit_width-1:0];
  assign mem_wr_data = in_data;

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_ptr[addr_bit_width-1:0];

  assign level = level_w'(mem_count) + level_w'(rd_pending) + level_w'(ob_count);

  // Capture slot: when a read lands the buffer holds at most one word, so the
  // tail is the head itself (empty) or the other slot (one word).
  assign ob_tail = ob_head ^ ob_count[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      ob_count   <= 2'd0;
      ob_head    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_w'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + ptr_w'(1);
      end
      rd_pending <= issue;
      ob_count   <= ob_next;
      if (pop) begin
        ob_head <= ~ob_head;
      end
    end
  end

  // Buffer payload needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && rd_pending) begin
      ob_mem[ob_tail] <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard testbench for mem_fifo_ctrl with a behavioural memory_dp
`timescale 1ns/1ps

module tb_mem_fifo_ctrl;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LW = $clog2(N + 3);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  mem_fifo_ctrl #(
    .num_mem_entries(N),
    .data_bit_width (DW),
    .addr_bit_width (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .level      (level)
  );

  // memory_dp model: synchronous write, registered read
  logic [DW-1:0] mem_model [N];
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem_model[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem_model[mem_rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: reference model is an ordered queue of accepted words; level is
  // simply words accepted minus words delivered.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      chk("level", 64'(level), 64'(exp_q.size()));
      if (level < LW'(N)) chk("in_ready_when_not_full", 64'(in_ready), 64'd1);
      chk("wr_en_eq_push", 64'(mem_wr_en), 64'(in_valid && in_ready));
      if (mem_wr_en && mem_rd_en)
        chk("rd_wr_same_addr", 64'(mem_wr_addr != mem_rd_addr), 64'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      cyc_start();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      if (level == '0 && !out_valid) done = 1;
    end
    chk(name, 64'(done), 64'd1);
  endtask

  initial begin
    int base;
    int idx;
    bit seen;

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    out_ready = 1'b1;

    // reset state
    for (int c = 0; c < 3; c++) begin
      cyc_start();
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
      chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    end
    cyc_start();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // single word latency
    cyc_start();
    in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
    @(negedge clk);
    chk("single_accept", 64'(in_ready), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc_start();
      in_valid = 1'b0;
      @(negedge clk);
      if (k < 3) chk("single_early_valid", 64'(out_valid), 64'd0);
      if (k == 3) begin
        chk("single_valid_t3", 64'(out_valid), 64'd1);
        chk("single_data_t3", 64'(out_data), 64'hA5);
      end
      if (k == 4) chk("single_level_t4", 64'(level), 64'd0);
    end

    // fill with no output backpressure relief
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      cyc_start();
      in_valid = 1'b1; in_data = DW'(i); out_ready = 1'b0;
      @(negedge clk);
      chk("fill_in_ready", 64'(in_ready), 64'd1);
    end
    cyc_start();
    in_valid = 1'b1; in_data = 32'hDEAD;
    @(negedge clk);
    chk("fill_full_in_ready", 64'(in_ready), 64'd0);
    chk("fill_level_10", 64'(level), 64'd10);
    drain("fill_drain");
    chk("fill_out_count", 64'(n_out - base), 64'd10);

    // streaming, one word per cycle after 3-cycle latency
    for (int k = 0; k < 37; k++) begin
      cyc_start();
      out_ready = 1'b1;
      in_valid  = (k < 32);
      in_data   = DW'(k);
      @(negedge clk);
      if (k < 32) chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (k >= 3 && k < 35) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data", 64'(out_data), 64'(k - 3));
      end
    end
    drain("stream_drain");

    // random backpressure
    base = n_out;
    idx  = 0;
    for (int c = 0; c < 4000 && idx < 256; c++) begin
      cyc_start();
      in_valid  = 1'b1;
      in_data   = DW'(idx);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (in_ready) idx++;
    end
    chk("bp_all_pushed", 64'(idx), 64'd256);
    drain("bp_drain");
    chk("bp_out_count", 64'(n_out - base), 64'd256);

    // reset mid-stream with level 5 and a read in flight
    for (int i = 0; i < 6; i++) begin
      cyc_start();
      in_valid = 1'b1; in_data = 32'h100 + DW'(i); out_ready = 1'b0;
      @(negedge clk);
    end
    cyc_start();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    cyc_start();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h99; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level_before", 64'(level), 64'd5);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_wr_en", 64'(mem_wr_en), 64'd0);
    chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
    cyc_start();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_level", 64'(level), 64'd0);
    chk("midrst_push_77", 64'(in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cyc_start();
      in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        chk("midrst_next_out", 64'(out_data), 64'h77);
      end
    end
    chk("midrst_out_seen", 64'(seen), 64'd1);
    drain("final_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
